// File: rtl/tick_gen.sv
// tick_gen: multi-channel runtime-programmable divider producing a one-cycle strobe and a
// near-50% square wave per channel. Optional macro TICK_GEN_SYNC_EN adds the tick_gen_sync realign input.
module tick_gen #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                fsys,
    input  logic                tick_gen_rst,
    input  logic                tick_gen_en,
    input  logic                tick_gen_ld,
    input  logic [CW-1:0]       tick_gen_ch,
    input  logic [WIDTH-1:0]    tick_gen_div,
`ifdef TICK_GEN_SYNC_EN
    input  logic                tick_gen_sync,
`endif
    output logic                tick_gen_ld_ack,
    output logic [CHANNELS-1:0] tick_gen_pulse,
    output logic [CHANNELS-1:0] tick_gen_out
);

    logic w_ld_ok;
    logic w_sync;
    logic r_ld_ack;

    assign w_ld_ok = tick_gen_ld && (int'(tick_gen_ch) < CHANNELS);

`ifdef TICK_GEN_SYNC_EN
    assign w_sync = tick_gen_sync;
`else
    assign w_sync = 1'b0;
`endif

    // Load acknowledge register: one cycle after every accepted load.
    always_ff @(posedge fsys or posedge tick_gen_rst) begin
        if (tick_gen_rst) begin
            r_ld_ack <= 1'b0;
        end else begin
            r_ld_ack <= w_ld_ok;
        end
    end

    assign tick_gen_ld_ack = r_ld_ack;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_div;
        logic [WIDTH-1:0] r_pend;
        logic             r_pend_v;
        logic             r_pulse;
        logic             r_out;

        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] w_div_nxt;
        logic [WIDTH-1:0] w_pend_nxt;
        logic             w_pend_v_nxt;
        logic             w_pend_v_kept;
        logic             w_pulse_nxt;
        logic             w_out_nxt;
        logic             w_apply;
        logic             w_active;
        logic             w_wrap;
        logic             w_ld_hit;
        logic [WIDTH-1:0] w_inc;
        logic [WIDTH-1:0] w_thresh;

        // w_thresh = N - (N>>1): out is high for the last floor(N/2) counts of a period.
        assign w_active = (r_div >= WIDTH'(2));
        assign w_wrap   = (r_cnt >= (r_div - WIDTH'(1)));
        assign w_inc    = r_cnt + WIDTH'(1);
        assign w_thresh = r_div - (r_div >> 1);
        assign w_ld_hit = w_ld_ok && (int'(tick_gen_ch) == g);

        // Next-state logic: sync beats idle beats enable; divisor swaps only at wrap, idle or sync.
        always_comb begin
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = r_out;
            w_pulse_nxt = 1'b0;
            w_apply     = 1'b0;
            if (w_sync) begin
                w_cnt_nxt = {WIDTH{1'b0}};
                w_out_nxt = 1'b0;
                w_apply   = r_pend_v;
            end else if (!w_active) begin
                w_cnt_nxt = {WIDTH{1'b0}};
                w_out_nxt = 1'b0;
                w_apply   = r_pend_v;
            end else if (tick_gen_en) begin
                if (w_wrap) begin
                    w_cnt_nxt   = {WIDTH{1'b0}};
                    w_pulse_nxt = 1'b1;
                    w_out_nxt   = 1'b0;
                    w_apply     = r_pend_v;
                end else begin
                    w_cnt_nxt = w_inc;
                    w_out_nxt = (w_inc >= w_thresh);
                end
            end else begin
                w_cnt_nxt = r_cnt;
                w_out_nxt = r_out;
            end

            if (w_apply) begin
                w_div_nxt     = r_pend;
                w_pend_v_kept = 1'b0;
            end else begin
                w_div_nxt     = r_div;
                w_pend_v_kept = r_pend_v;
            end

            // A load on the same edge as a wrap becomes pending for the following wrap.
            if (w_ld_hit) begin
                w_pend_nxt   = tick_gen_div;
                w_pend_v_nxt = 1'b1;
            end else begin
                w_pend_nxt   = r_pend;
                w_pend_v_nxt = w_pend_v_kept;
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge fsys or posedge tick_gen_rst) begin
            if (tick_gen_rst) begin
                r_cnt    <= {WIDTH{1'b0}};
                r_div    <= WIDTH'(DEFAULT_DIV);
                r_pend   <= {WIDTH{1'b0}};
                r_pend_v <= 1'b0;
                r_pulse  <= 1'b0;
                r_out    <= 1'b0;
            end else begin
                r_cnt    <= w_cnt_nxt;
                r_div    <= w_div_nxt;
                r_pend   <= w_pend_nxt;
                r_pend_v <= w_pend_v_nxt;
                r_pulse  <= w_pulse_nxt;
                r_out    <= w_out_nxt;
            end
        end

        assign tick_gen_pulse[g] = r_pulse;
        assign tick_gen_out[g]   = r_out;
    end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a cycle model pushes expected {ack,pulse,out} per edge,
// a monitor pops and compares after each edge; directed checks pin the key timing points.
module tb_tick_gen;

    localparam int CH = 3;
    localparam int W  = 16;
    localparam int CW = 2;

    logic          fsys;
    logic          tick_gen_rst;
    logic          tick_gen_en;
    logic          tick_gen_ld;
    logic [CW-1:0] tick_gen_ch;
    logic [W-1:0]  tick_gen_div;
`ifdef TICK_GEN_SYNC_EN
    logic          tick_gen_sync;
`endif
    logic          tick_gen_ld_ack;
    logic [CH-1:0] tick_gen_pulse;
    logic [CH-1:0] tick_gen_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int sb_q[$];

    int m_cnt  [CH];
    int m_div  [CH];
    int m_pend [CH];
    bit m_pv   [CH];
    bit m_out  [CH];

    tick_gen #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(4)) dut (
        .fsys            (fsys),
        .tick_gen_rst    (tick_gen_rst),
        .tick_gen_en     (tick_gen_en),
        .tick_gen_ld     (tick_gen_ld),
        .tick_gen_ch     (tick_gen_ch),
        .tick_gen_div    (tick_gen_div),
`ifdef TICK_GEN_SYNC_EN
        .tick_gen_sync   (tick_gen_sync),
`endif
        .tick_gen_ld_ack (tick_gen_ld_ack),
        .tick_gen_pulse  (tick_gen_pulse),
        .tick_gen_out    (tick_gen_out)
    );

    initial begin
        fsys = 1'b0;
        forever #5 fsys = ~fsys;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c]  = 0;
            m_div[c]  = 4;
            m_pend[c] = 0;
            m_pv[c]   = 1'b0;
            m_out[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit en, input bit ld, input int ch, input int din,
                              input bit sync, output int exp);
        bit ack;
        bit app;
        bit p;
        int pulse_v;
        int out_v;
        ack     = ld && (ch < CH);
        pulse_v = 0;
        out_v   = 0;
        for (int c = 0; c < CH; c++) begin
            app = 1'b0;
            p   = 1'b0;
            if (sync) begin
                m_cnt[c] = 0;
                m_out[c] = 1'b0;
                app      = m_pv[c];
            end else if (m_div[c] < 2) begin
                m_cnt[c] = 0;
                m_out[c] = 1'b0;
                app      = m_pv[c];
            end else if (en) begin
                if (m_cnt[c] + 1 == m_div[c]) begin
                    p        = 1'b1;
                    m_cnt[c] = 0;
                    m_out[c] = 1'b0;
                    app      = m_pv[c];
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                    m_out[c] = (m_cnt[c] > (m_div[c] - 1) / 2);
                end
            end
            if (app) begin
                m_div[c] = m_pend[c];
                m_pv[c]  = 1'b0;
            end
            if (ack && ch == c) begin
                m_pend[c] = din;
                m_pv[c]   = 1'b1;
            end
            pulse_v = pulse_v | (int'(p) << c);
            out_v   = out_v | (int'(m_out[c]) << c);
        end
        exp = (int'(ack) << (2 * CH)) | (pulse_v << CH) | out_v;
    endtask

    task automatic drive(input bit en, input bit ld, input int ch, input int din, input bit sync);
        int exp;
        tick_gen_en  = en;
        tick_gen_ld  = ld;
        tick_gen_ch  = CW'(ch);
        tick_gen_div = W'(din);
`ifdef TICK_GEN_SYNC_EN
        tick_gen_sync = sync;
`endif
        model_edge(en, ld, ch, din, sync, exp);
        sb_q.push_back(exp);
        @(posedge fsys);
        #2;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 0, 0, 1'b0);
        end
    endtask

    // Monitor: pop one expected vector per edge once the DUT outputs have settled.
    initial begin
        int exp;
        int obs;
        forever begin
            @(posedge fsys);
            #1;
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                obs = {25'd0, tick_gen_ld_ack, tick_gen_pulse, tick_gen_out};
                chk("sb", obs, exp);
            end
        end
    end

    initial begin
        tick_gen_rst = 1'b1;
        tick_gen_en  = 1'b0;
        tick_gen_ld  = 1'b0;
        tick_gen_ch  = '0;
        tick_gen_div = '0;
`ifdef TICK_GEN_SYNC_EN
        tick_gen_sync = 1'b0;
`endif
        model_reset();
        #2;
        chk("rst_pulse", int'(tick_gen_pulse), 0);
        chk("rst_out", int'(tick_gen_out), 0);
        chk("rst_ack", int'(tick_gen_ld_ack), 0);
        repeat (2) @(posedge fsys);
        #2;
        tick_gen_rst = 1'b0;
        cyc = 0;

        // Default divisor 4 on every channel
        run(2);
        chk("c2_out", int'(tick_gen_out), 7);
        run(2);
        chk("c4_pulse", int'(tick_gen_pulse), 7);
        run(2);
        drive(1'b1, 1'b1, 1, 5, 1'b0);
        chk("c7_ack", int'(tick_gen_ld_ack), 1);
        run(1);
        chk("c8_pulse", int'(tick_gen_pulse), 7);
        run(4);
        chk("c12_pulse", int'(tick_gen_pulse), 5);
        run(1);
        chk("c13_pulse", int'(tick_gen_pulse), 2);
        run(5);
        chk("c18_pulse", int'(tick_gen_pulse), 2);

        // Idle channel 2, then revive it with N=3
        drive(1'b1, 1'b1, 2, 0, 1'b0);
        run(4);
        chk("c23_pulse", int'(tick_gen_pulse), 2);
        chk("c23_out2", int'(tick_gen_out[2]), 0);
        run(1);
        chk("c24_pulse", int'(tick_gen_pulse), 1);
        drive(1'b1, 1'b1, 2, 3, 1'b0);
        run(4);
        chk("c29_pulse", int'(tick_gen_pulse), 4);
        run(1);

        // Enable stall with ch0 at count 2
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 0, 0, 1'b0);
            chk("stall_pulse", int'(tick_gen_pulse), 0);
            chk("stall_out", int'(tick_gen_out), 1);
        end
        run(1);
        chk("c34_pulse0", int'(tick_gen_pulse[0]), 0);
        run(1);
        chk("c35_pulse0", int'(tick_gen_pulse[0]), 1);

        // Out-of-range channel is ignored
        drive(1'b1, 1'b1, CH, 9, 1'b0);
        chk("bad_ch_ack", int'(tick_gen_ld_ack), 0);
        run(3);

        // Asynchronous reset mid-count
        tick_gen_rst = 1'b1;
        #1;
        chk("mid_rst_pulse", int'(tick_gen_pulse), 0);
        chk("mid_rst_out", int'(tick_gen_out), 0);
        chk("mid_rst_ack", int'(tick_gen_ld_ack), 0);
        model_reset();
        repeat (2) @(posedge fsys);
        #2;
        tick_gen_rst = 1'b0;
        cyc = 0;
        run(2);
        chk("r2_out", int'(tick_gen_out), 7);
        run(2);
        chk("r4_pulse", int'(tick_gen_pulse), 7);

`ifdef TICK_GEN_SYNC_EN
        // Put ch1 on N=8 out of phase with ch0, then sync while disabled
        drive(1'b1, 1'b1, 1, 6, 1'b0);
        run(6);
        drive(1'b1, 1'b1, 1, 8, 1'b0);
        run(7);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        chk("sync_pulse", int'(tick_gen_pulse), 0);
        chk("sync_out", int'(tick_gen_out), 0);
        run(4);
        chk("sync4_pulse", int'(tick_gen_pulse), 5);
        run(4);
        chk("sync8_pulse", int'(tick_gen_pulse), 7);
`endif

        run(2);
        chk("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
# tick_gen

Multi-channel programmable tick and clock-enable generator clocked from `fsys`. Each channel divides `fsys` by its own runtime-loadable integer divisor, not just a power of two. Each channel produces a one-cycle strobe and a near-50%-duty square wave. It replaces single-counter tap selection wherever several independent, exactly-divided rates are needed, such as display refresh, debounce sampling or counter stepping.

## Interface
- `CHANNELS`, 4: number of independent divider channels (≥1).
- `WIDTH`, 16: divisor and per-channel counter width.
- `DEFAULT_DIV`, 4: divisor loaded into every channel at reset (≥2).

Ports:
- `fsys`  in  1  system clock; the single clock of the block.
- `tick_gen_rst`  in  1  reset, asynchronous, active-high.
- `tick_gen_en`  in  1  global count enable.
- `tick_gen_ld`  in  1  divisor load request, sampled on each edge.
- `tick_gen_ch`  in  max(1,$clog2(CHANNELS))  target channel of the load.
- `tick_gen_div`  in  WIDTH  divisor value N to load.
- `tick_gen_ld_ack`  out  1  one-cycle acknowledge of an accepted load.
- `tick_gen_pulse`  out  CHANNELS  per-channel one-cycle strobe, once per N enabled cycles.
- `tick_gen_out`  out  CHANNELS  per-channel square wave, period N enabled cycles.
- `tick_gen_sync`  in  1  realign all channels; present only with `TICK_GEN_SYNC_EN`.

## Operation
- Per-channel state:
  - `cnt` (WIDTH bits): the counter.
  - `div` (active divisor).
  - `pend` plus `pend_v`: shadow divisor and its valid flag.
  - Registered outputs `pulse` and `out`.
- H = N>>1. A channel is active for N≥2 and idle for N∈{0,1}.
- Active channel, on an edge with `tick_gen_en`=1:
  - `cnt` steps 0,1,…,N−1,0.
  - `pulse` <= (cnt==N−1).
  - `out` <= (cnt_next ≥ N−H), so `out` is high for the last H counts of each period.
  - Odd N: `out` is low for one more cycle than it is high.
- Wrap edge (cnt==N−1 while enabled):
  - If `pend_v`, then `div` <= `pend`, `pend_v` <= 0, and `cnt` <= 0.
  - The divisor change is glitch-free. The current period always completes with the old N.
- `tick_gen_en`=0:
  - `cnt`, `out` and `div` hold.
  - `pulse` is forced to 0.
  - Pending loads wait for the next wrap.
- Idle channel (div<2):
  - `cnt`=0, `out`=0 and `pulse`=0 are held.
  - A pending divisor is applied on the next edge regardless of `tick_gen_en`.
- Load:
  - If `tick_gen_ld`=1 and `tick_gen_ch`<CHANNELS, then `pend[ch]` <= `tick_gen_div` and `pend_v` <= 1.
  - `tick_gen_ld_ack` pulses on the following cycle.
  - If `tick_gen_ch`≥CHANNELS, the load is ignored and no ack is given.
  - A reload before the previous pending value is applied overwrites it (last write wins).
- Load on the same edge as that channel's wrap: the wrap consumes the old `pend` if one is valid. The new value becomes pending and applies at the following wrap.
- Channels are fully independent. Only `tick_gen_en` and the reset (plus `tick_gen_sync`) are shared.

## Timing
- Reset values:
  - `cnt`=0, `div`=DEFAULT_DIV, `pend_v`=0.
  - `tick_gen_pulse`=0, `tick_gen_out`=0, `tick_gen_ld_ack`=0.
- Reset is applied immediately and asynchronously, including in the middle of a period. Its release is synchronous to `fsys`.
- After reset release with en=1 and N=DEFAULT_DIV=4:
  - `pulse` is high after edges 4, 8, 12, ….
  - `out` is high after edges 2–3, 6–7, ….
  - `pulse` coincides with the falling edge of `out`.
- All outputs are registered, with no combinational path from input to output.
- Load-to-ack latency is 1 cycle. Load-to-effect occurs at the next wrap, or on the next edge if the channel is idle.

## Configuration
- `TICK_GEN_SYNC_EN`, when defined:
  - The `tick_gen_sync` port exists.
  - On an edge with sync=1, every channel sets `cnt`<=0, `pulse`<=0 and `out`<=0, and applies any pending divisor immediately.
  - Sync has priority over `tick_gen_en` and over wrap.
  - After sync, channels with commensurate divisors issue coincident pulses.
- Without the macro, the port is absent. Channels realign only through reset.

## Test plan
- Reset, then en=1 with DEFAULT_DIV=4 on all channels → every `pulse` is high at edges 4, 8, 12, and `out` is high at edges 2–3 and 6–7, all channels identical.
- Load N=5 to ch1 at edge 6 → `ld_ack` is high at edge 7. Ch1 completes its 4-cycle period with a pulse at edge 8, then pulses at 13 and 18 with `out` high for 2 of every 5 cycles. Ch0 is unaffected.
- Load N=0 to ch2 → ch2 goes idle at its next wrap, with `out`, `pulse` and `cnt` held at 0. Then load N=3 → ch2 runs from the next edge and pulses every 3 cycles.
- Drop en for 3 cycles with ch0 at cnt=2 → no pulses and `out` frozen. On re-enable the first pulse occurs 2 enabled cycles later, so the period is unchanged apart from the stall.
- Load with ch=CHANNELS → no ack and no state change. Assert reset at mid-count → all outputs are 0 at once, and the sequence restarts exactly as in the first test.
- With `TICK_GEN_SYNC_EN`, set ch0 N=4 and ch1 N=8 running out of phase, then pulse sync → both channels restart from 0, ch1's pulse coincides with every second ch0 pulse, and the sync priority over en=0 is also checked.
